switch_debounce: RTL and testbench

- Upstream input-conditioning stage for the switch/IO read path.
- Takes raw asynchronous board DIP switches and one push button. Synchronises each into the core clock domain and debounces it per bit.
- Presents a glitch-free 8-bit switch value. The IO read stage samples this value when the controller issues an IO read.
- Also produces a one-cycle confirm pulse from the button and a one-cycle change-notify pulse.

---
 rtl/switch_debounce.sv | 95 +++++++++
 tb/tb_switch_debounce.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Switch/button input conditioning: 2-flop synchroniser plus per-bit debounce counter.
// Latency: a held raw change reaches the outputs DEBOUNCE_CYCLES+2 clocks after it is first sampled.
// Backpressure: none; the outputs are level/pulse registers that downstream samples when it needs them.
//
// Ports:
//   clock          core clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   switch_raw     raw asynchronous board switches
//   button_raw     raw asynchronous confirm button, 1 = pressed
//   switch_stable  debounced switch value (feeds the IO read stage)
//   button_level   debounced button level
//   button_pulse   one-cycle pulse on debounced button press
//   switch_changed one-cycle pulse when any switch_stable bit changes
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 230000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switch_raw,
    input  logic             button_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic             button_level,
    output logic             button_pulse,
    output logic             switch_changed
);

    // The button is handled as one extra bit on top of the switches, so
    // every bit goes through exactly the same synchroniser and debouncer.
    localparam int NB = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw_all;
    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync2_q;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    stable_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic             pulse_q;
    logic             pulse_d;
    logic             changed_q;
    logic             changed_d;

    assign raw_all = {button_raw, switch_raw};

    // A counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement clears it, which is what rejects glitches.
    // Reaching CNT_MAX accepts the new level and restarts from zero, so the
    // counter can never pass CNT_MAX or wrap.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        pulse_d   = stable_d[WIDTH] & ~stable_q[WIDTH];
        changed_d = |(stable_d[WIDTH-1:0] ^ stable_q[WIDTH-1:0]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pulse_q   <= 1'b0;
            changed_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_all;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pulse_q   <= pulse_d;
            changed_q <= changed_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign switch_stable  = stable_q[WIDTH-1:0];
    assign button_level   = stable_q[WIDTH];
    assign button_pulse   = pulse_q;
    assign switch_changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios with literal checks, plus a
// window-based reference model compared against the DUT on every negedge.
// Latency/backpressure: n/a (testbench).
module tb_switch_debounce;

    localparam int WIDTH = 8;
    localparam int DC    = 4;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] switch_raw;
    logic             button_raw;
    logic [WIDTH-1:0] switch_stable;
    logic             button_level;
    logic             button_pulse;
    logic             switch_changed;

    int total;
    int bad;

    switch_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .switch_raw(switch_raw),
        .button_raw(button_raw),
        .switch_stable(switch_stable),
        .button_level(button_level),
        .button_pulse(button_pulse),
        .switch_changed(switch_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a bit flips once the last DC synchronised samples
    // all disagree with its accepted level. The synchronised sample used
    // at an edge is the raw value captured two edges earlier.
    logic [WIDTH:0]   m_hist[$];
    logic [WIDTH:0]   m_ev[$];
    logic [WIDTH-1:0] m_stable;
    logic             m_level;
    logic             m_pulse;
    logic             m_changed;

    always @(posedge clock or negedge reset_n) begin
        logic [WIDTH:0] cur;
        logic [WIDTH:0] nxt;
        logic           all_diff;
        if (!reset_n) begin
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            m_ev.delete();
            m_stable  = '0;
            m_level   = 1'b0;
            m_pulse   = 1'b0;
            m_changed = 1'b0;
        end else begin
            cur = {m_level, m_stable};
            m_ev.push_back(m_hist[0]);
            if (m_ev.size() > DC) void'(m_ev.pop_front());
            m_hist.push_back({button_raw, switch_raw});
            if (m_hist.size() > 2) void'(m_hist.pop_front());
            nxt = cur;
            if (m_ev.size() == DC) begin
                for (int b = 0; b <= WIDTH; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DC; k++) begin
                        if (m_ev[k][b] == cur[b]) all_diff = 1'b0;
                    end
                    if (all_diff) nxt[b] = ~cur[b];
                end
            end
            m_pulse   = nxt[WIDTH] & ~cur[WIDTH];
            m_changed = (nxt[WIDTH-1:0] != cur[WIDTH-1:0]);
            m_stable  = nxt[WIDTH-1:0];
            m_level   = nxt[WIDTH];
        end
    end

    always @(negedge clock) begin
        total++;
        if (switch_stable !== m_stable) begin
            bad++;
            $display("FAIL model_stable t=%0t got=%h want=%h", $time, switch_stable, m_stable);
        end
        total++;
        if (button_level !== m_level) begin
            bad++;
            $display("FAIL model_level t=%0t got=%b want=%b", $time, button_level, m_level);
        end
        total++;
        if (button_pulse !== m_pulse) begin
            bad++;
            $display("FAIL model_pulse t=%0t got=%b want=%b", $time, button_pulse, m_pulse);
        end
        total++;
        if (switch_changed !== m_changed) begin
            bad++;
            $display("FAIL model_changed t=%0t got=%b want=%b", $time, switch_changed, m_changed);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    int cnt;
    int when;
    int ever_nonzero;

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        switch_raw = 8'hFF;
        button_raw = 1'b0;

        // Reset held with inputs high: everything stays 0.
        repeat (5) step();
        check("rst_stable", 32'(switch_stable), 32'h00);
        check("rst_changed", 32'(switch_changed), 32'h0);
        reset_n = 1'b1;
        repeat (5) step();
        check("rel_edge5", 32'(switch_stable), 32'h00);
        step();
        check("rel_edge6", 32'(switch_stable), 32'hFF);
        check("rel_changed6", 32'(switch_changed), 32'h1);
        step();
        check("rel_changed7", 32'(switch_changed), 32'h0);

        // Clean change 00 -> A5.
        switch_raw = 8'h00;
        repeat (10) step();
        check("clean_pre", 32'(switch_stable), 32'h00);
        switch_raw = 8'hA5;
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 5) check("clean_edge5", 32'(switch_stable), 32'h00);
            if (i == 6) check("clean_edge6", 32'(switch_stable), 32'hA5);
            if (switch_changed) cnt++;
        end
        check("clean_pulses", 32'(cnt), 32'd1);

        // Glitch of 3 clocks on bit 3 is rejected.
        switch_raw = 8'h00;
        repeat (12) step();
        switch_raw = 8'h08;
        repeat (3) step();
        switch_raw = 8'h00;
        cnt = 0;
        ever_nonzero = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (switch_changed) cnt++;
            if (switch_stable != 8'h00) ever_nonzero++;
        end
        check("glitch3_changed", 32'(cnt), 32'd0);
        check("glitch3_stable", 32'(ever_nonzero), 32'd0);

        // A 4-clock pulse is long enough to be accepted.
        switch_raw = 8'h08;
        repeat (4) step();
        switch_raw = 8'h00;
        step();
        check("pulse4_edge5", 32'(switch_stable), 32'h00);
        step();
        check("pulse4_edge6", 32'(switch_stable), 32'h08);
        repeat (12) step();
        check("pulse4_back", 32'(switch_stable), 32'h00);

        // Button bouncing every 2 clocks, then settling high.
        cnt = 0;
        for (int seg = 0; seg < 10; seg++) begin
            button_raw = ((seg % 2) == 0);
            repeat (2) begin
                step();
                if (button_pulse) cnt++;
            end
        end
        check("bounce_none", 32'(cnt), 32'd0);
        button_raw = 1'b1;
        when = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (button_pulse) begin
                cnt++;
                when = i;
            end
        end
        check("bounce_pulses", 32'(cnt), 32'd1);
        check("bounce_when", 32'(when), 32'd6);
        check("bounce_level", 32'(button_level), 32'h1);
        button_raw = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (button_pulse) cnt++;
        end
        check("release_nopulse", 32'(cnt), 32'd0);
        check("release_level", 32'(button_level), 32'h0);

        // Staggered bits 0 and 7.
        switch_raw = 8'h01;
        step();
        switch_raw = 8'h81;
        repeat (4) step();
        check("stag_edge5", 32'(switch_stable), 32'h00);
        step();
        check("stag_edge6", 32'(switch_stable), 32'h01);
        check("stag_chg6", 32'(switch_changed), 32'h1);
        step();
        check("stag_edge7", 32'(switch_stable), 32'h81);
        check("stag_chg7", 32'(switch_changed), 32'h1);
        step();
        check("stag_chg8", 32'(switch_changed), 32'h0);

        // Reset in the middle of a count.
        switch_raw = 8'h0F;
        repeat (4) step();
        check("mid_before", 32'(switch_stable), 32'h81);
        reset_n = 1'b0;
        #1;
        check("mid_async", 32'(switch_stable), 32'h00);
        repeat (4) step();
        reset_n = 1'b1;
        repeat (5) step();
        check("mid_edge5", 32'(switch_stable), 32'h00);
        step();
        check("mid_edge6", 32'(switch_stable), 32'h0F);
        check("mid_chg6", 32'(switch_changed), 32'h1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
